// File: rtl/stim_pulse_gen.sv
// Two-pulse stimulus sequencer.
// One accepted start produces: wait dly1, stim1 for plen cycles, wait dly2, then stim2 for
// plen cycles. Delay and length values are captured when the sequence starts. A value of 0
// behaves as 1. done strobes as stim2 falls, and seq_cnt counts completed sequences.
module stim_pulse_gen #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] dly1,
  input  logic [CNT_W-1:0] dly2,
  input  logic [LEN_W-1:0] plen,
  output logic             stim1,
  output logic             stim2,
  output logic             busy,
  output logic             done,
  output logic [7:0]       seq_cnt
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StWait1,
    StPulse1,
    StWait2,
    StPulse2
  } state_e;

  state_e           r_state;
  state_e           w_state_d;

  // Captured sequence parameters; dly1 goes straight into the delay counter.
  logic [CNT_W-1:0] r_dly2;
  logic [LEN_W-1:0] r_plen;

  // Counters hold "cycles remaining minus one", so a phase ends when the counter reads 0.
  logic [CNT_W-1:0] r_dly_cnt;
  logic [CNT_W-1:0] w_dly_cnt_d;
  logic [LEN_W-1:0] r_len_cnt;
  logic [LEN_W-1:0] w_len_cnt_d;

  logic             r_stim1;
  logic             r_stim2;
  logic             r_done;
  logic [7:0]       r_seq_cnt;
  logic             w_stim1_d;
  logic             w_stim2_d;
  logic             w_done_d;
  logic [7:0]       w_seq_cnt_d;

  logic             w_dly_zero;
  logic             w_len_zero;
  logic [CNT_W-1:0] w_dly1_ld;
  logic [CNT_W-1:0] w_dly2_ld;
  logic [LEN_W-1:0] w_plen_ld;

  assign w_dly_zero = (r_dly_cnt == '0);
  assign w_len_zero = (r_len_cnt == '0);

  // Load values: effective length minus one, with 0 treated as 1 so nothing ever wraps.
  assign w_dly1_ld = (dly1 == '0) ? '0 : dly1 - CntOne;
  assign w_dly2_ld = (r_dly2 == '0) ? '0 : r_dly2 - CntOne;
  assign w_plen_ld = (r_plen == '0) ? '0 : r_plen - LenOne;

  // State register and all registered outputs/datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_dly2    <= '0;
      r_plen    <= '0;
      r_dly_cnt <= '0;
      r_len_cnt <= '0;
      r_stim1   <= 1'b0;
      r_stim2   <= 1'b0;
      r_done    <= 1'b0;
      r_seq_cnt <= '0;
    end else begin
      r_state   <= w_state_d;
      r_dly_cnt <= w_dly_cnt_d;
      r_len_cnt <= w_len_cnt_d;
      r_stim1   <= w_stim1_d;
      r_stim2   <= w_stim2_d;
      r_done    <= w_done_d;
      r_seq_cnt <= w_seq_cnt_d;
      if (r_state == StIdle && start) begin
        r_dly2 <= dly2;
        r_plen <= plen;
      end
    end
  end

  // Next-state decode; abort wins over phase completion, start wins over abort in idle.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (start) w_state_d = StWait1;
      end
      StWait1: begin
        if (abort)           w_state_d = StIdle;
        else if (w_dly_zero) w_state_d = StPulse1;
      end
      StPulse1: begin
        if (abort)           w_state_d = StIdle;
        else if (w_len_zero) w_state_d = StWait2;
      end
      StWait2: begin
        if (abort)           w_state_d = StIdle;
        else if (w_dly_zero) w_state_d = StPulse2;
      end
      StPulse2: begin
        if (abort)           w_state_d = StIdle;
        else if (w_len_zero) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Counter next values: load on phase entry, count down within a phase.
  always_comb begin
    w_dly_cnt_d = r_dly_cnt;
    w_len_cnt_d = r_len_cnt;
    unique case (r_state)
      StIdle: begin
        if (start) w_dly_cnt_d = w_dly1_ld;
      end
      StWait1: begin
        if (!w_dly_zero) w_dly_cnt_d = r_dly_cnt - CntOne;
        else             w_len_cnt_d = w_plen_ld;
      end
      StPulse1: begin
        if (!w_len_zero) w_len_cnt_d = r_len_cnt - LenOne;
        else             w_dly_cnt_d = w_dly2_ld;
      end
      StWait2: begin
        if (!w_dly_zero) w_dly_cnt_d = r_dly_cnt - CntOne;
        else             w_len_cnt_d = w_plen_ld;
      end
      StPulse2: begin
        if (!w_len_zero) w_len_cnt_d = r_len_cnt - LenOne;
      end
      default: begin
        w_dly_cnt_d = '0;
        w_len_cnt_d = '0;
      end
    endcase
  end

  // Output decode from the next state, so stim edges line up with state transitions.
  always_comb begin
    w_stim1_d   = (w_state_d == StPulse1);
    w_stim2_d   = (w_state_d == StPulse2);
    w_done_d    = (r_state == StPulse2) && w_len_zero && !abort;
    // 8-bit counter wraps naturally from 255 to 0.
    w_seq_cnt_d = r_seq_cnt + {7'd0, w_done_d};
  end

  assign stim1   = r_stim1;
  assign stim2   = r_stim2;
  assign done    = r_done;
  assign seq_cnt = r_seq_cnt;
  assign busy    = (r_state != StIdle);

endmodule

// File: tb/tb_stim_pulse_gen.sv
// Bench for stim_pulse_gen: each launched sequence pushes its four expected output edges
// (with absolute cycle numbers) into a queue; a negedge monitor pops and compares them.
module tb_stim_pulse_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] dly1;
  logic [15:0] dly2;
  logic [7:0]  plen;
  logic        stim1;
  logic        stim2;
  logic        busy;
  logic        done;
  logic [7:0]  seq_cnt;

  stim_pulse_gen dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .dly1    (dly1),
    .dly2    (dly2),
    .plen    (plen),
    .stim1   (stim1),
    .stim2   (stim2),
    .busy    (busy),
    .done    (done),
    .seq_cnt (seq_cnt)
  );

  always #5 clk = ~clk;

  // Edge kinds: 0 stim1 rise, 1 stim1 fall, 2 stim2 rise, 3 stim2 fall with done.
  typedef struct {
    int         kind;
    int         t;
    logic [7:0] cnt;
  } ev_t;

  ev_t        q[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [7:0] model_cnt = 8'd0;
  bit         mon_quiet = 1'b1;
  logic       p1 = 1'b0;
  logic       p2 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every stim edge must match the head of the queue.
  always @(negedge clk) begin
    ev_t ev;
    if (!mon_quiet) begin
      if (stim1 === 1'b1 && stim2 === 1'b1) begin
        total++; bad++;
        $display("FAIL overlap: stim1 and stim2 both high at cycle %0d", cyc);
      end
      if (stim1 !== p1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL stim1_edge: unexpected edge to %b at cycle %0d", stim1, cyc);
        end else begin
          ev = q.pop_front();
          if (ev.kind !== (stim1 ? 0 : 1) || ev.t !== cyc) begin
            bad++;
            $display("FAIL stim1_edge: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                     stim1 ? 0 : 1, cyc, ev.kind, ev.t);
          end
        end
      end
      if (stim2 !== p2) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL stim2_edge: unexpected edge to %b at cycle %0d", stim2, cyc);
        end else begin
          ev = q.pop_front();
          if (ev.kind !== (stim2 ? 2 : 3) || ev.t !== cyc ||
              (ev.kind == 3 && (done !== 1'b1 || seq_cnt !== ev.cnt))) begin
            bad++;
            $display("FAIL stim2_edge: got kind %0d cyc %0d done %b cnt %0d, required kind %0d cyc %0d done %b cnt %0d",
                     stim2 ? 2 : 3, cyc, done, seq_cnt, ev.kind, ev.t, ev.kind == 3, ev.cnt);
          end
        end
      end else if (done !== 1'b0) begin
        total++; bad++;
        $display("FAIL done_strobe: done=%b at cycle %0d, required 0", done, cyc);
      end
    end
    p1 = stim1;
    p2 = stim2;
  end

  // Move to a quiet point just after the negedge monitor has run.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic push_seq(input int d1, input int d2, input int pl, input int t0);
    int a;
    int l;
    a = t0 + eff(d1);
    l = eff(pl);
    model_cnt = model_cnt + 8'd1;
    q.push_back('{kind: 0, t: a, cnt: 8'd0});
    q.push_back('{kind: 1, t: a + l, cnt: 8'd0});
    q.push_back('{kind: 2, t: a + l + eff(d2), cnt: 8'd0});
    q.push_back('{kind: 3, t: a + l + eff(d2) + l, cnt: model_cnt});
  endtask

  // Drive start for one edge (T0 = next edge) and scramble inputs afterwards.
  task automatic launch(input logic [15:0] d1, input logic [15:0] d2, input logic [7:0] pl);
    dly1  = d1;
    dly2  = d2;
    plen  = pl;
    start = 1'b1;
    push_seq(int'(d1), int'(d2), int'(pl), cyc + 1);
    step();
    start = 1'b0;
    dly1  = 16'($urandom);
    dly2  = 16'($urandom);
    plen  = 8'($urandom);
  endtask

  task automatic wait_idle(input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      if (q.size() == 0 && busy === 1'b0) break;
      step();
    end
    total++;
    if (q.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_timeout: %0d events pending, busy=%b, required 0 and 0",
               name, q.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    step();
    step();
    total += 5;
    if (stim1 !== 1'b0)   begin bad++; $display("FAIL reset_stim1: got %b, required 0", stim1); end
    if (stim2 !== 1'b0)   begin bad++; $display("FAIL reset_stim2: got %b, required 0", stim2); end
    if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (done !== 1'b0)    begin bad++; $display("FAIL reset_done: got %b, required 0", done); end
    if (seq_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt: got %0d, required 0", seq_cnt); end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    model_cnt = 8'd0;
    mon_quiet = 1'b0;
    step();
  endtask

  task automatic test_long();
    launch(16'd100, 16'd150, 8'd4);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL long_busy: got %b, required 1", busy); end
    wait_idle(400, "long");
    total++;
    if (seq_cnt !== model_cnt) begin
      bad++; $display("FAIL long_cnt: got %0d, required %0d", seq_cnt, model_cnt);
    end
  endtask

  task automatic test_zero();
    launch(16'd0, 16'd0, 8'd0);
    wait_idle(20, "zero");
    launch(16'd1, 16'd3, 8'd2);
    wait_idle(30, "small");
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    logic [7:0] c0;
    c0    = seq_cnt;
    dly1  = 16'd3; dly2 = 16'd2; plen = 8'd2;
    start = 1'b1;
    t0    = cyc + 1;
    push_seq(3, 2, 2, t0);
    t1    = t0 + 3 + 2 + 2 + 2 + 1;
    push_seq(3, 2, 2, t1);
    step();
    // Toggle start while busy; hold it high for the edge right after done.
    while (cyc < t1) begin
      start = (cyc == t1 - 1) ? 1'b1 : cyc[0];
      step();
    end
    start = 1'b0;
    wait_idle(40, "b2b");
    total++;
    if (seq_cnt !== c0 + 8'd2) begin
      bad++; $display("FAIL b2b_cnt: got %0d, required %0d", seq_cnt, c0 + 8'd2);
    end
  endtask

  task automatic test_abort();
    // abort in idle does nothing
    abort = 1'b1;
    step();
    step();
    abort = 1'b0;
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_abort_busy: got %b, required 0", busy); end
    if (seq_cnt !== model_cnt) begin
      bad++; $display("FAIL idle_abort_cnt: got %0d, required %0d", seq_cnt, model_cnt);
    end
    // abort during PULSE1
    launch(16'd5, 16'd3, 8'd6);
    for (int i = 0; i < 20; i++) begin
      if (stim1 === 1'b1) break;
      step();
    end
    step();
    mon_quiet = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    q.delete();
    model_cnt = model_cnt - 8'd1;
    total += 5;
    if (stim1 !== 1'b0) begin bad++; $display("FAIL abort_stim1: got %b, required 0", stim1); end
    if (stim2 !== 1'b0) begin bad++; $display("FAIL abort_stim2: got %b, required 0", stim2); end
    if (busy !== 1'b0)  begin bad++; $display("FAIL abort_busy: got %b, required 0", busy); end
    if (done !== 1'b0)  begin bad++; $display("FAIL abort_done: got %b, required 0", done); end
    if (seq_cnt !== model_cnt) begin
      bad++; $display("FAIL abort_cnt: got %0d, required %0d", seq_cnt, model_cnt);
    end
    mon_quiet = 1'b0;
    launch(16'd2, 16'd1, 8'd3);
    wait_idle(30, "after_abort");
    // start and abort together in idle: start wins
    abort = 1'b1;
    launch(16'd2, 16'd2, 8'd1);
    abort = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL start_abort_busy: got %b, required 1", busy); end
    wait_idle(30, "start_abort");
  endtask

  task automatic test_reset_mid();
    int t0;
    t0 = cyc + 1;
    launch(16'd4, 16'd6, 8'd2);
    while (cyc < t0 + 4 + 2 + 1 && cyc < t0 + 50) step();
    mon_quiet = 1'b1;
    rst = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    total += 5;
    if (stim1 !== 1'b0)   begin bad++; $display("FAIL midrst_stim1: got %b, required 0", stim1); end
    if (stim2 !== 1'b0)   begin bad++; $display("FAIL midrst_stim2: got %b, required 0", stim2); end
    if (busy !== 1'b0)    begin bad++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    if (done !== 1'b0)    begin bad++; $display("FAIL midrst_done: got %b, required 0", done); end
    if (seq_cnt !== 8'd0) begin bad++; $display("FAIL midrst_cnt: got %0d, required 0", seq_cnt); end
    q.delete();
    model_cnt = 8'd0;
    rst = 1'b0;
    mon_quiet = 1'b0;
    // first edge with rst low must accept start
    launch(16'd0, 16'd0, 8'd0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL post_rst_start: busy %b, required 1", busy); end
    wait_idle(20, "post_rst");
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    mon_quiet = 1'b1;
    step();
    rst = 1'b0;
    model_cnt = 8'd0;
    mon_quiet = 1'b0;
    for (int i = 0; i < 256; i++) begin
      launch(16'd0, 16'd0, 8'd0);
      wait_idle(20, "wrap");
      if (i == 254) begin
        total++;
        if (seq_cnt !== 8'd255) begin
          bad++; $display("FAIL wrap_255: got %0d, required 255", seq_cnt);
        end
      end
    end
    total++;
    if (seq_cnt !== 8'd0) begin bad++; $display("FAIL wrap_zero: got %0d, required 0", seq_cnt); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    dly1 = '0; dly2 = '0; plen = '0;
    step();
    test_reset();
    test_long();
    test_zero();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_wrap();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stim_pulse_gen.md
STIM_PULSE_GEN -- requirements
Module: stim_pulse_gen

Interface
REQ-001 Parameter CNT_W, default 16: width of the delay inputs and delay counter.
REQ-002 Parameter LEN_W, default 8: width of the pulse-length input and pulse counter.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-005 Port start, input, 1 bit: request a stimulus sequence; sampled only in IDLE.
REQ-006 Port abort, input, 1 bit: cancel an in-progress sequence.
REQ-007 Port dly1, input, CNT_W bits: cycles from start acceptance to the stim1 rising edge.
REQ-008 Port dly2, input, CNT_W bits: cycles from the stim1 falling edge to the stim2 rising edge.
REQ-009 Port plen, input, LEN_W bits: pulse width in cycles, shared by stim1 and stim2.
REQ-010 Port stim1, output, 1 bit: first stimulus pulse; registered.
REQ-011 Port stim2, output, 1 bit: second stimulus pulse; registered.
REQ-012 Port busy, output, 1 bit: high in every state except IDLE.
REQ-013 Port done, output, 1 bit: one-cycle completion strobe.
REQ-014 Port seq_cnt, output, 8 bits: count of completed sequences.

Function
REQ-015 FSM states SHALL be IDLE, WAIT1, PULSE1, WAIT2, PULSE2.
REQ-016 In IDLE with start=1 at edge T0: dly1, dly2 and plen SHALL be latched, and the FSM SHALL enter WAIT1.
REQ-017 Input changes after T0 SHALL NOT affect the running sequence.
REQ-018 A latched delay or length of 0 SHALL be treated as 1.
REQ-019 stim1 SHALL rise at edge T0+D1, where D1 is the effective dly1; state becomes PULSE1.
REQ-020 stim1 SHALL stay high for exactly L cycles (L = effective plen) and fall at edge T0+D1+L; state becomes WAIT2.
REQ-021 stim2 SHALL rise at edge T0+D1+L+D2; state becomes PULSE2.
REQ-022 stim2 SHALL fall at edge T0+D1+L+D2+L.
REQ-023 At the edge where stim2 falls: done=1 for one cycle, busy=0, seq_cnt increments, state returns to IDLE.
REQ-024 stim1 and stim2 SHALL never be high in the same cycle.
REQ-025 start while busy=1 SHALL be ignored, with no queuing.
REQ-026 start sampled in the cycle where done=1 (state IDLE) SHALL be accepted; back-to-back sequences are legal.
REQ-027 abort=1 in any non-IDLE state: at the next edge, stim1=0, stim2=0, busy=0, state IDLE; done stays 0 and seq_cnt is unchanged.
REQ-028 abort in IDLE SHALL have no effect.
REQ-029 When start and abort are both 1 in IDLE, start SHALL win and the sequence begins.
REQ-030 seq_cnt SHALL wrap from 255 to 0 without any flag.
REQ-031 Counters SHALL count down from the latched value; no counter SHALL wrap during a sequence.

Reset
REQ-032 rst=1 at an edge SHALL force state IDLE, stim1=0, stim2=0, busy=0, done=0, seq_cnt=0, and clear the latched registers and counters.
REQ-033 rst SHALL take priority over start and abort.
REQ-034 rst asserted mid-sequence SHALL produce the same reset values, with no done strobe.
REQ-035 After rst deasserts, the first start SHALL be accepted at the first edge with rst=0.

Verification
REQ-036 dly1=100, dly2=150, plen=4, start at T0 -> stim1 high edges T0+100..T0+103 (falls at T0+104), stim2 rises at T0+254, falls at T0+258 with done=1, seq_cnt=1.
REQ-037 dly1=0, dly2=0, plen=0 -> treated as 1/1/1: stim1 rises at T0+1 and falls at T0+2, stim2 rises at T0+3 and falls at T0+4 with done.
REQ-038 start pulsed repeatedly during a busy sequence -> one sequence only; a start in the done cycle launches a second sequence -> seq_cnt=2.
REQ-039 abort during PULSE1 -> stim1=0 at the next edge, busy=0, no done, seq_cnt unchanged; a following start runs normally.
REQ-040 rst during WAIT2 -> all outputs 0 at the next edge; 256 completed sequences -> seq_cnt reads 0.
